// File: rtl/auth_seq_blk.sv
// auth_seq_blk: multi-byte go-code authorisation for the Segway power enable.
// Every received byte is acknowledged one cycle later. A configurable go code,
// with an inter-byte timeout, powers the machine up. Repeated failures lock the
// block out for a fixed period. A stop byte, followed by the rider stepping off,
// drops power.
module auth_seq_blk #(
  parameter int                     CODE_LEN    = 2,
  parameter logic [CODE_LEN*8-1:0]  GO_CODE     = 16'h4731,
  parameter logic [7:0]             STOP_CODE   = 8'h53,
  parameter int                     TIMEOUT_CYC = 1_000_000,
  parameter int                     MAX_FAIL    = 3,
  parameter int                     LOCK_CYC    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       rider_off,
  output logic       clr_rx_rdy,
  output logic       pwr_up,
  output logic       auth_fail,
  output logic       locked
);

  // Counter widths. Each is at least one bit, so degenerate 1-cycle settings still elaborate.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYC - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAIL);
  localparam logic [FW-1:0] F_ONE  = FW'(1);
  localparam logic [2:0]    LEN3   = 3'(CODE_LEN);
  localparam logic [1:0]    I_ONE  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PWR1,
    S_PWR2,
    S_REAUTH,
    S_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [LW-1:0]   lk_cnt_q, lk_cnt_d;
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
  logic            fail_pulse_d;

  logic            clr_rx_rdy_q;
  logic            pwr_up_q;
  logic            auth_fail_q;
  logic            locked_q;

  // Code bytes unpacked MSB-first; slots beyond CODE_LEN are never addressed.
  logic [7:0] code_byte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_code
    if (gi < CODE_LEN) begin : g_used
      assign code_byte[gi] = GO_CODE[8*(CODE_LEN-1-gi) +: 8];
    end else begin : g_unused
      assign code_byte[gi] = 8'h00;
    end
  end

  // Per-cycle byte classification shared by the code-collecting states.
  logic first_hit;
  logic stop_hit;
  logic byte_mismatch;
  logic timeout_hit;
  logic last_byte;

  assign first_hit     = rx_rdy && (rx_data == code_byte[0]);
  assign stop_hit      = rx_rdy && (rx_data == STOP_CODE);
  assign byte_mismatch = rx_rdy && (rx_data != code_byte[idx_q]);
  assign timeout_hit   = (tmr_q == T_LAST);
  assign last_byte     = (({1'b0, idx_q} + 3'd1) == LEN3);

  // Next-state logic: sequencing, timeout, failure accounting and lockout timing.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    lk_cnt_d     = lk_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Non-matching bytes are silently dropped and do not count as failures.
        if (first_hit) begin
          tmr_d = '0;
          if (LEN3 == 3'd1) begin
            state_d    = S_PWR1;
            idx_d      = '0;
            fail_cnt_d = '0;
          end else begin
            state_d = S_COLLECT;
            idx_d   = I_ONE;
          end
        end
      end

      S_COLLECT: begin
        // A timeout wins over a byte arriving in the same cycle.
        if (timeout_hit || byte_mismatch) begin
          fail_pulse_d = 1'b1;
          idx_d        = '0;
          tmr_d        = '0;
          fail_cnt_d   = (fail_cnt_q == F_MAX) ? fail_cnt_q : fail_cnt_q + F_ONE;
          if ((fail_cnt_q + F_ONE) == F_MAX) begin
            state_d  = S_LOCKOUT;
            lk_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rx_rdy) begin
          tmr_d = '0;
          if (last_byte) begin
            state_d    = S_PWR1;
            idx_d      = '0;
            fail_cnt_d = '0;
          end else begin
            idx_d = idx_q + I_ONE;
          end
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end

      S_PWR1: begin
        // Only a stop byte moves on; rider_off by itself keeps power up.
        if (stop_hit) begin
          state_d = rider_off ? S_IDLE : S_PWR2;
        end
      end

      S_PWR2: begin
        if (rider_off) begin
          state_d = S_IDLE;
        end else if (first_hit) begin
          tmr_d = '0;
          if (LEN3 == 3'd1) begin
            state_d = S_PWR1;
            idx_d   = '0;
          end else begin
            state_d = S_REAUTH;
            idx_d   = I_ONE;
          end
        end
      end

      S_REAUTH: begin
        // Power stays on during re-authorisation; a failure here is not counted.
        if (rider_off) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end else if (timeout_hit || byte_mismatch) begin
          state_d = S_PWR2;
          idx_d   = '0;
          tmr_d   = '0;
        end else if (rx_rdy) begin
          tmr_d = '0;
          if (last_byte) begin
            state_d = S_PWR1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + I_ONE;
          end
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end

      S_LOCKOUT: begin
        // Bytes are still acknowledged but otherwise ignored until expiry.
        if (lk_cnt_q == L_LAST) begin
          state_d    = S_IDLE;
          lk_cnt_d   = '0;
          fail_cnt_d = '0;
        end else begin
          lk_cnt_d = lk_cnt_q + L_ONE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        idx_d      = '0;
        tmr_d      = '0;
        lk_cnt_d   = '0;
        fail_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tmr_q        <= '0;
      lk_cnt_q     <= '0;
      fail_cnt_q   <= '0;
      clr_rx_rdy_q <= 1'b0;
      pwr_up_q     <= 1'b0;
      auth_fail_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      lk_cnt_q     <= lk_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      clr_rx_rdy_q <= rx_rdy;
      pwr_up_q     <= (state_d == S_PWR1) || (state_d == S_PWR2) || (state_d == S_REAUTH);
      auth_fail_q  <= fail_pulse_d;
      locked_q     <= (state_d == S_LOCKOUT);
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign pwr_up     = pwr_up_q;
  assign auth_fail  = auth_fail_q;
  assign locked     = locked_q;

endmodule
